// File: rtl/spi_wb_master.sv
// SPI slave (mode 0, MSB first, 16-bit words) bridged to a classic-cycle
// Wishbone master. Frame = {rw, addr} header followed by auto-incrementing
// data words. The SPI pins are oversampled in the sys_clk domain.
module spi_wb_master #(
  parameter int unsigned ADDR_WIDTH  = 15,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WB_TIMEOUT  = 255
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  spi_sck,
  input  logic                  spi_ss_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [15:0]           wb_dat_o,
  input  logic [15:0]           wb_dat_i,
  output logic [2:0]            wb_cti_o,
  output logic [1:0]            wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  output logic [1:0]            err_o
);

  typedef enum logic [1:0] {SPI_IDLE, SPI_HEADER, SPI_DATA} spi_state_e;
  typedef enum logic {WB_IDLE, WB_BUSY} wb_state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_fall;

  spi_state_e             state_q, state_d;
  wb_state_e              wb_state_q, wb_state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [15:0]            rx_shift_q, rx_shift_d;
  logic [15:0]            tx_shift_q, tx_shift_d;
  logic                   rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   miso_q, miso_d;
  logic                   rd_wait_q, rd_wait_d;
  logic [1:0]             err_q, err_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
  logic [15:0]            dat_q, dat_d;
  logic [7:0]             tmo_q, tmo_d;

  logic [15:0]            rx_word;
  logic                   req, req_we, leave;
  logic [ADDR_WIDTH-1:0]  req_adr;

  // Synchronise SPI pins and keep the previous synced level for edge detection
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sck_sync_q  <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  // Next-state logic: SPI framing first, then bus issue, then bus completion.
  // rd_wait marks a read whose data still belongs on MISO; completion uses the
  // already-updated value so a late word or a frame end discards the data.
  always_comb begin
    state_d    = state_q;
    wb_state_d = wb_state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    miso_d     = miso_q;
    rd_wait_d  = rd_wait_q;
    err_d      = err_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    tmo_d      = tmo_q;
    rx_word    = {rx_shift_q[14:0], mosi_s};
    req        = 1'b0;
    req_we     = 1'b0;
    req_adr    = addr_q;
    leave      = 1'b0;

    case (state_q)
      SPI_IDLE: begin
        miso_d    = 1'b0;
        rd_wait_d = 1'b0;
        bit_cnt_d = '0;
        if (ss_fall) state_d = SPI_HEADER;
      end
      default: begin
        if (sck_rise) begin
          rx_shift_d = rx_word;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          if (state_q == SPI_DATA && rw_q && bit_cnt_q == 4'd0 && rd_wait_q) begin
            err_d[1]  = 1'b1;
            rd_wait_d = 1'b0;
          end
          if (bit_cnt_q == 4'd15) begin
            if (state_q == SPI_HEADER) begin
              rw_d    = rx_word[15];
              addr_d  = rx_word[ADDR_WIDTH-1:0];
              state_d = SPI_DATA;
              req     = rx_word[15];
              req_adr = rx_word[ADDR_WIDTH-1:0];
            end else if (rw_q) begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              req     = 1'b1;
              req_adr = addr_q + ADDR_WIDTH'(1);
            end else begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              req     = 1'b1;
              req_we  = 1'b1;
              req_adr = addr_q;
            end
          end
        end else if (sck_fall && state_q == SPI_DATA && rw_q && bit_cnt_q != 4'd0) begin
          tx_shift_d = {tx_shift_q[14:0], 1'b0};
          miso_d     = tx_shift_q[14];
        end
        if (ss_s) begin
          leave     = 1'b1;
          state_d   = SPI_IDLE;
          bit_cnt_d = '0;
        end
      end
    endcase

    if (req) begin
      if (!req_we) begin
        tx_shift_d = '0;
        miso_d     = 1'b0;
      end
      if (wb_state_q == WB_IDLE) begin
        wb_state_d = WB_BUSY;
        cyc_d      = 1'b1;
        we_d       = req_we;
        adr_d      = req_adr;
        tmo_d      = '0;
        if (req_we) dat_d = rx_word;
        else        rd_wait_d = 1'b1;
      end else begin
        err_d[1] = 1'b1;
      end
    end

    if (leave) begin
      miso_d    = 1'b0;
      rd_wait_d = 1'b0;
    end

    if (wb_state_q == WB_BUSY) begin
      if (wb_ack_i) begin
        wb_state_d = WB_IDLE;
        cyc_d      = 1'b0;
        we_d       = 1'b0;
        if (!we_q && rd_wait_d) begin
          tx_shift_d = wb_dat_i;
          miso_d     = wb_dat_i[15];
          rd_wait_d  = 1'b0;
        end
      end else if (tmo_q == 8'(WB_TIMEOUT - 1)) begin
        wb_state_d = WB_IDLE;
        cyc_d      = 1'b0;
        we_d       = 1'b0;
        err_d[0]   = 1'b1;
        if (!we_q && rd_wait_d) begin
          tx_shift_d = '0;
          miso_d     = 1'b0;
          rd_wait_d  = 1'b0;
        end
      end else begin
        tmo_d = tmo_q + 8'd1;
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= SPI_IDLE;
      wb_state_q <= WB_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      miso_q     <= 1'b0;
      rd_wait_q  <= 1'b0;
      err_q      <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      wb_state_q <= wb_state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      miso_q     <= miso_d;
      rd_wait_q  <= rd_wait_d;
      err_q      <= err_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      tmo_q      <= tmo_d;
    end
  end

  assign spi_miso = miso_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_cti_o = '0;
  assign wb_sel_o = '1;
  assign wb_we_o  = we_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_spi_wb_master.sv
// Scoreboard bench for spi_wb_master: an SPI host drives frames, expected
// Wishbone accesses and MISO words are queued from a memory-level model,
// and a bus monitor checks every access the bridge presents.
module tb_spi_wb_master;

  localparam int unsigned AW = 15;
  localparam int HALF = 80;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          spi_sck   = 1'b0;
  logic          spi_ss_n  = 1'b1;
  logic          spi_mosi  = 1'b0;
  logic          spi_miso;
  logic [AW-1:0] wb_adr_o;
  logic [15:0]   wb_dat_o;
  logic [15:0]   wb_dat_i;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
  logic [1:0]    err_o;

  always #5 sys_clk = ~sys_clk;

  spi_wb_master #(.ADDR_WIDTH(AW), .SYNC_STAGES(2), .WB_TIMEOUT(255)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_cti_o(wb_cti_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .err_o(err_o)
  );

  typedef struct {
    bit          we;
    logic [14:0] adr;
    logic [15:0] dat;
    bit          tmo;
    bit          chk_end;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] miso_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  bit   [15:0] slv_mem [32768];
  bit          slv_wr  [32768];
  bit   [15:0] ref_mem [32768];
  bit          ref_wr  [32768];
  bit          ack_en = 1'b1;
  logic [15:0] fd [8];

  function automatic logic [15:0] dflt(input logic [14:0] a);
    return {a, 1'b1} ^ 16'h3C5A;
  endfunction

  function automatic logic [15:0] ref_read(input logic [14:0] a);
    return ref_wr[a] ? ref_mem[a] : dflt(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Wishbone slave memory, one-cycle ack when enabled
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= '0;
    end else if (wb_cyc_o && wb_stb_o && !wb_ack_i && ack_en) begin
      wb_ack_i <= 1'b1;
      if (wb_we_o) begin
        slv_mem[wb_adr_o] <= wb_dat_o;
        slv_wr[wb_adr_o]  <= 1'b1;
      end else begin
        wb_dat_i <= slv_wr[wb_adr_o] ? slv_mem[wb_adr_o] : dflt(wb_adr_o);
      end
    end else begin
      wb_ack_i <= 1'b0;
    end
  end

  // Bus monitor: pops an expectation at every cycle start, checks its end
  initial begin : monitor
    exp_t        cur;
    bit          prev_cyc, acked, stable;
    int          dur;
    logic [14:0] l_adr;
    logic [15:0] l_dat;
    logic        l_we;
    prev_cyc = 1'b0; acked = 1'b0; stable = 1'b1; dur = 0;
    l_adr = '0; l_dat = '0; l_we = 1'b0;
    cur = '{we: 1'b0, adr: '0, dat: '0, tmo: 1'b0, chk_end: 1'b0};
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        prev_cyc = 1'b0;
      end else begin
        if (wb_cyc_o && !prev_cyc) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wb_unexpected: access adr 0x%0h we %0b, required none", wb_adr_o, wb_we_o);
            cur = '{we: 1'b0, adr: '0, dat: '0, tmo: 1'b0, chk_end: 1'b0};
          end else begin
            cur = exp_q.pop_front();
            chk("wb_adr", 32'(wb_adr_o), 32'(cur.adr));
            chk("wb_we", 32'(wb_we_o), 32'(cur.we));
            if (cur.we) chk("wb_dat", 32'(wb_dat_o), 32'(cur.dat));
            chk("wb_sel_cti", 32'({wb_sel_o, wb_cti_o}), 32'h18);
          end
          l_adr = wb_adr_o; l_dat = wb_dat_o; l_we = wb_we_o;
          dur = 0; acked = 1'b0; stable = 1'b1;
        end
        if (wb_cyc_o) begin
          dur++;
          if (wb_ack_i) acked = 1'b1;
          if (wb_adr_o !== l_adr || wb_we_o !== l_we || wb_stb_o !== 1'b1 ||
              (l_we && wb_dat_o !== l_dat)) stable = 1'b0;
        end
        if (!wb_cyc_o && prev_cyc && cur.chk_end) begin
          chk("wb_stable", 32'(stable), 32'd1);
          chk("wb_acked", 32'(acked), 32'(!cur.tmo));
          if (cur.tmo) chk("wb_timeout_len", 32'(dur), 32'd255);
        end
        prev_cyc = wb_cyc_o;
      end
    end
  end

  task automatic spi_bits(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[15-i];
      #HALF spi_sck = 1'b1;
      rx[15-i] = spi_miso;
      #HALF spi_sck = 1'b0;
    end
  endtask

  task automatic ss_begin();
    @(negedge sys_clk);
    spi_ss_n = 1'b0;
    #(4*HALF);
  endtask

  task automatic ss_end();
    #HALF spi_ss_n = 1'b1;
    #(4*HALF);
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    repeat (4) @(negedge sys_clk);
    while (wb_cyc_o && k < lim) begin
      @(negedge sys_clk);
      k++;
    end
    chk("wb_idle", 32'(wb_cyc_o), 32'd0);
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic write_frame(input logic [14:0] a, input int n);
    logic [15:0] rx;
    logic [14:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = a + 15'(i);
      exp_q.push_back('{we: 1'b1, adr: ad, dat: fd[i], tmo: 1'b0, chk_end: 1'b1});
      ref_mem[ad] = fd[i];
      ref_wr[ad]  = 1'b1;
    end
    ss_begin();
    spi_bits({1'b0, a}, 16, rx);
    for (int i = 0; i < n; i++) spi_bits(fd[i], 16, rx);
    ss_end();
    wait_idle(400);
  endtask

  task automatic read_frame(input logic [14:0] a, input int n, input bit tmo);
    logic [15:0] rx, ex;
    for (int i = 0; i <= n; i++)
      exp_q.push_back('{we: 1'b0, adr: a + 15'(i), dat: '0, tmo: tmo, chk_end: 1'b1});
    for (int i = 0; i < n; i++)
      miso_q.push_back(tmo ? 16'h0000 : ref_read(a + 15'(i)));
    ss_begin();
    spi_bits({1'b1, a}, 16, rx);
    if (tmo) repeat (300) @(negedge sys_clk);
    for (int i = 0; i < n; i++) begin
      spi_bits(16'($urandom), 16, rx);
      ex = miso_q.pop_front();
      chk("miso_word", 32'(rx), 32'(ex));
    end
    ss_end();
    wait_idle(tmo ? 800 : 400);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] rx;
    int          k;
    // reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_adr_dat", 32'({wb_adr_o, wb_dat_o}), 32'd0);
    chk("rst_miso", 32'(spi_miso), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_sel_cti", 32'({wb_sel_o, wb_cti_o}), 32'h18);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);

    // directed write
    fd[0] = 16'hABCD; fd[1] = 16'h1234;
    write_frame(15'h0012, 2);
    // directed read of preloaded words
    fd[0] = 16'h5A5A; fd[1] = 16'hC3C3;
    write_frame(15'h0040, 2);
    read_frame(15'h0040, 2, 1'b0);
    // address wrap
    fd[0] = 16'h1111; fd[1] = 16'h2222;
    write_frame(15'h7FFF, 2);
    read_frame(15'h7FFF, 2, 1'b0);
    // aborted write word, then a clean write
    ss_begin();
    spi_bits(16'h0200, 16, rx);
    spi_bits(16'hFFFF, 7, rx);
    ss_end();
    wait_idle(100);
    fd[0] = 16'hBEEF;
    write_frame(15'h0100, 1);
    read_frame(15'h0100, 1, 1'b0);
    read_frame(15'h0200, 1, 1'b0);
    chk("err_clean", 32'(err_o), 32'd0);

    // randomized frames
    for (int f = 0; f < 12; f++) begin
      int n;
      logic [14:0] a;
      n = int'($urandom_range(1, 4));
      a = 15'($urandom);
      if (f % 4 == 3) a = 15'h7FFE;
      for (int i = 0; i < n; i++) fd[i] = 16'($urandom);
      if ($urandom_range(0, 1) == 0) write_frame(a, n);
      else read_frame(a, n, 1'b0);
    end
    chk("err_after_random", 32'(err_o), 32'd0);

    // slave never acks
    ack_en = 1'b0;
    read_frame(15'h0005, 1, 1'b1);
    chk("err_timeout", 32'(err_o), 32'd1);

    // async reset while a cycle is open
    exp_q.push_back('{we: 1'b0, adr: 15'h0055, dat: '0, tmo: 1'b0, chk_end: 1'b0});
    ss_begin();
    spi_bits(16'h8055, 16, rx);
    k = 0;
    while (!wb_cyc_o && k < 100) begin
      @(negedge sys_clk);
      k++;
    end
    chk("rst_cyc_open", 32'(wb_cyc_o), 32'd1);
    repeat (3) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_mid_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_mid_we", 32'(wb_we_o), 32'd0);
    chk("rst_mid_err", 32'(err_o), 32'd0);
    spi_ss_n = 1'b1;
    ack_en   = 1'b1;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    fd[0] = 16'h600D; fd[1] = 16'hF00D;
    write_frame(15'h0300, 2);
    read_frame(15'h0300, 2, 1'b0);
    chk("err_final", 32'(err_o), 32'd0);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("miso_q_drained", 32'(miso_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
